// File: rtl/dmem_responder_pkg.sv
// Shared widths and build defaults for the CPU data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = DataW / 8;

  // Build defaults: posted writes on, bus timeout of 255 request cycles.
  localparam bit          DmemPostedWr = 1'b1;
  localparam int unsigned DmemTimeout  = 255;

  // Counter width for a given timeout; a disabled timeout (0) still needs one bit.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Registered req/ack system bus between the data-memory responder and the bus fabric.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic             req;
  logic [AddrW-1:0] addr;
  logic [BeW-1:0]   we;
  logic [DataW-1:0] wdata;
  logic             ack;
  logic [DataW-1:0] rdata;

  modport master (output req, addr, we, wdata, input ack, rdata);
  modport slave  (input req, addr, we, wdata, output ack, rdata);

endinterface

// File: rtl/dmem_responder_bus_timer.sv
// Request-cycle counter with a single-cycle timeout pulse on the last allowed cycle.
module dmem_responder_bus_timer
  import dmem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = DmemTimeout
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_timeout
);

  localparam int unsigned     Width = timer_width(TIMEOUT);
  localparam logic [Width-1:0] Last = Width'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_timeout = (TIMEOUT != 0) && i_en && (cnt_q == Last);

endmodule

// File: rtl/dmem_responder.sv
// Target side of the CPU data port: runs each access on the req/ack bus, with an optional
// one-entry posted-write buffer and a bus timeout.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter bit          POSTED_WR = DmemPostedWr,
  parameter int unsigned TIMEOUT   = DmemTimeout
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cpu_ce,
  input  logic [AddrW-1:0] i_addr,
  input  logic [BeW-1:0]   i_we,
  input  logic             i_rd,
  input  logic [DataW-1:0] i_wdata,
  output logic [DataW-1:0] o_rdata,
  output logic             o_valid,
  dmem_responder_if.master bus,
  output logic             o_bus_err
);

  typedef enum logic [1:0] {StIdle, StBus, StHold, StDrain} state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [BeW-1:0]   we_q, we_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [DataW-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic is_write, is_read, is_access;
  logic issue_bus, issue_post;
  logic timeout, done, timer_clr;

  assign is_write  = |i_we;
  assign is_read   = i_rd & ~is_write;
  assign is_access = i_rd | is_write;

  // Reads and unposted writes stall the CPU, so they issue regardless of i_cpu_ce.
  assign issue_bus  = is_read | (is_write & ~POSTED_WR);
  assign issue_post = is_write & POSTED_WR & i_cpu_ce;

  // A timeout completes the transfer exactly like an ack, but with zero data.
  assign done      = req_q & (bus.ack | timeout);
  assign timer_clr = done;

  dmem_responder_bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (req_q),
    .i_clr     (timer_clr),
    .o_timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    o_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        o_valid = ~is_access | (is_write & POSTED_WR);
        if (issue_bus || issue_post) begin
          req_d   = 1'b1;
          addr_d  = i_addr;
          we_d    = is_write ? i_we : '0;
          wdata_d = i_wdata;
          state_d = issue_bus ? StBus : StDrain;
        end
      end
      StBus: begin
        if (done) begin
          req_d   = 1'b0;
          rdata_d = (bus.ack && (we_q == '0)) ? bus.rdata : '0;
          err_d   = err_q | ~bus.ack;
          state_d = StHold;
        end
      end
      StHold: begin
        o_valid = 1'b1;
        if (i_cpu_ce) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        o_valid = ~is_access;
        if (done) begin
          req_d   = 1'b0;
          err_d   = err_q | ~bus.ack;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_rdata   = (state_q == StHold) ? rdata_q : '0;
  assign o_bus_err = err_q;
  assign bus.req   = req_q;
  assign bus.addr  = addr_q;
  assign bus.we    = we_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a posted/TIMEOUT=4 instance and an unposted/TIMEOUT=255 instance,
// each behind a RAM-like bus slave, checked against a CPU-level memory model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cpu_ce [2];
  logic [31:0] addr   [2];
  logic [3:0]  we     [2];
  logic        rd     [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic        valid  [2];
  logic        err    [2];

  logic        b_req   [2];
  logic [31:0] b_addr  [2];
  logic [3:0]  b_we    [2];
  logic [31:0] b_wdata [2];
  logic        b_ack   [2];
  logic [31:0] b_rdata [2];

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign b_req[0] = bus0.req;   assign b_addr[0] = bus0.addr;
  assign b_we[0]  = bus0.we;    assign b_wdata[0] = bus0.wdata;
  assign bus0.ack = b_ack[0];   assign bus0.rdata = b_rdata[0];
  assign b_req[1] = bus1.req;   assign b_addr[1] = bus1.addr;
  assign b_we[1]  = bus1.we;    assign b_wdata[1] = bus1.wdata;
  assign bus1.ack = b_ack[1];   assign bus1.rdata = b_rdata[1];

  dmem_responder #(.POSTED_WR(1'b1), .TIMEOUT(4)) dut_p (
    .i_clk (clk), .i_rst_n (rst_n), .i_cpu_ce (cpu_ce[0]), .i_addr (addr[0]), .i_we (we[0]),
    .i_rd (rd[0]), .i_wdata (wdata[0]), .o_rdata (rdata[0]), .o_valid (valid[0]),
    .bus (bus0), .o_bus_err (err[0])
  );

  dmem_responder #(.POSTED_WR(1'b0), .TIMEOUT(255)) dut_n (
    .i_clk (clk), .i_rst_n (rst_n), .i_cpu_ce (cpu_ce[1]), .i_addr (addr[1]), .i_we (we[1]),
    .i_rd (rd[1]), .i_wdata (wdata[1]), .o_rdata (rdata[1]), .o_valid (valid[1]),
    .bus (bus1), .o_bus_err (err[1])
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] slv_mem [2][256];
  logic [31:0] ref_mem [2][256];
  txn_t        exp_q0 [$];
  txn_t        exp_q1 [$];

  bit          busy       [2];
  int          wcnt       [2];
  int          wtarget    [2];
  int          fixed_wait [2];
  bit          stall_ack  [2];
  bit          inject_ack [2];
  txn_t        cur        [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'hDEAD_BEEF : (32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // RAM-like bus slave: records each new request, checks it against the expected queue,
  // checks the request stays stable, and acks after a random or fixed wait.
  task automatic slave_step(input int d);
    txn_t t;
    bit   ok;
    b_ack[d]   = 1'b0;
    b_rdata[d] = $urandom;
    if (busy[d] && !b_req[d]) busy[d] = 1'b0;
    if (busy[d]) begin
      check_eq("bus_addr_stable", b_addr[d], cur[d].addr);
      check_eq("bus_we_stable", 32'(b_we[d]), 32'(cur[d].we));
      check_eq("bus_wdata_stable", b_wdata[d], cur[d].wdata);
    end else if (b_req[d]) begin
      busy[d]    = 1'b1;
      wcnt[d]    = 0;
      wtarget[d] = (fixed_wait[d] >= 0) ? fixed_wait[d] : int'($urandom_range(0, 3));
      cur[d]     = '{addr: b_addr[d], we: b_we[d], wdata: b_wdata[d]};
      ok = 1'b0;
      if (d == 0 && exp_q0.size() != 0) begin t = exp_q0.pop_front(); ok = 1'b1; end
      if (d == 1 && exp_q1.size() != 0) begin t = exp_q1.pop_front(); ok = 1'b1; end
      if (!ok) begin
        check_eq("unexpected_req", 32'(b_req[d]), 32'd0);
      end else begin
        check_eq("req_addr", b_addr[d], t.addr);
        check_eq("req_we", 32'(b_we[d]), 32'(t.we));
        if (t.we != 4'd0) check_eq("req_wdata", b_wdata[d], t.wdata);
      end
    end
    if (busy[d] && !stall_ack[d]) begin
      if (wcnt[d] == wtarget[d]) begin
        b_ack[d] = 1'b1;
        if (cur[d].we == 4'd0) b_rdata[d] = slv_mem[d][cur[d].addr[9:2]];
        else slv_mem[d][cur[d].addr[9:2]] = merge(slv_mem[d][cur[d].addr[9:2]],
                                                  cur[d].wdata, cur[d].we);
        busy[d] = 1'b0;
      end else begin
        wcnt[d]++;
      end
    end
    if (inject_ack[d]) begin
      b_ack[d]      = 1'b1;
      inject_ack[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      b_ack[d] = 1'b0; b_rdata[d] = '0; busy[d] = 1'b0;
      for (int i = 0; i < 256; i++) slv_mem[d][i] = init_word(i);
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) slave_step(d);
    end
  end

  task automatic present(input int d, input logic r, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] wd);
    txn_t t;
    rd[d] = r; we[d] = w; addr[d] = a; wdata[d] = wd;
    t = '{addr: a, we: w, wdata: wd};
    if (d == 0) exp_q0.push_back(t);
    else exp_q1.push_back(t);
  endtask

  // Wait for the CPU to see o_valid, check the data, optionally hold i_cpu_ce low, then consume.
  task automatic complete(input int d, input string tag);
    logic        is_wr;
    logic [31:0] exp;
    int          hold_extra, stall;
    bit          done;
    is_wr      = |we[d];
    exp        = is_wr ? 32'h0 : ref_mem[d][addr[d][9:2]];
    hold_extra = $urandom_range(0, 2);
    stall      = 0;
    done       = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (valid[d]) begin
        check_eq({tag, "_rdata"}, rdata[d], exp);
        if (hold_extra == 0) begin
          cpu_ce[d] = 1'b1;
          done      = 1'b1;
        end else begin
          hold_extra--;
          cpu_ce[d] = 1'b0;
        end
      end else begin
        cpu_ce[d] = 1'b0;
        stall++;
        if (stall > 40) begin
          check_eq({tag, "_valid"}, 32'(valid[d]), 32'd1);
          done = 1'b1;
        end
      end
      step();
    end
    if (is_wr) ref_mem[d][addr[d][9:2]] = merge(ref_mem[d][addr[d][9:2]], wdata[d], we[d]);
    cpu_ce[d] = 1'b0; rd[d] = 1'b0; we[d] = 4'd0;
  endtask

  task automatic run_access(input int d, input logic r, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] wd, input string tag);
    present(d, r, w, a, wd);
    complete(d, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt, kind, gap;
    bit          seen;
    logic [31:0] a, wd;
    logic [3:0]  wev;

    for (int d = 0; d < 2; d++) begin
      cpu_ce[d] = 1'b0; rd[d] = 1'b0; we[d] = 4'd0; addr[d] = '0; wdata[d] = '0;
      fixed_wait[d] = -1; stall_ack[d] = 1'b0; inject_ack[d] = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);
    end
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    step();

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_req", 32'(b_req[d]), 32'd0);
      check_eq("rst_addr", b_addr[d], 32'd0);
      check_eq("rst_we", 32'(b_we[d]), 32'd0);
      check_eq("rst_wdata", b_wdata[d], 32'd0);
      check_eq("rst_err", 32'(err[d]), 32'd0);
      check_eq("rst_rdata", rdata[d], 32'd0);
      check_eq("rst_valid", 32'(valid[d]), 32'd1);
    end
    step();

    // Read 0x100 with ack in the first request cycle, then hold the CPU for 3 cycles.
    fixed_wait[1] = 0;
    present(1, 1'b1, 4'd0, 32'h100, $urandom);
    @(negedge clk);
    check_eq("rd_c0_valid", 32'(valid[1]), 32'd0);
    check_eq("rd_c0_req", 32'(b_req[1]), 32'd0);
    step(); @(negedge clk);
    check_eq("rd_c1_valid", 32'(valid[1]), 32'd0);
    check_eq("rd_c1_req", 32'(b_req[1]), 32'd1);
    check_eq("rd_c1_addr", b_addr[1], 32'h100);
    check_eq("rd_c1_we", 32'(b_we[1]), 32'd0);
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rd_hold_valid", 32'(valid[1]), 32'd1);
      check_eq("rd_hold_rdata", rdata[1], 32'hDEAD_BEEF);
      check_eq("rd_hold_req", 32'(b_req[1]), 32'd0);
      if (c == 2) cpu_ce[1] = 1'b1;
      step();
    end
    cpu_ce[1] = 1'b0; rd[1] = 1'b0;
    fixed_wait[1] = -1;

    // Posted write then read on the posted instance; drain ack after two wait cycles.
    fixed_wait[0] = 2;
    present(0, 1'b0, 4'b0011, 32'h200, 32'h0000_55AA);
    cpu_ce[0] = 1'b1;
    @(negedge clk);
    check_eq("pw_c0_valid", 32'(valid[0]), 32'd1);
    step();
    ref_mem[0][128] = merge(ref_mem[0][128], 32'h0000_55AA, 4'b0011);
    present(0, 1'b1, 4'd0, 32'h200, $urandom);
    cpu_ce[0] = 1'b0;
    @(negedge clk);
    check_eq("pw_c1_valid", 32'(valid[0]), 32'd0);
    check_eq("pw_c1_req", 32'(b_req[0]), 32'd1);
    check_eq("pw_c1_we", 32'(b_we[0]), 32'b0011);
    check_eq("pw_c1_addr", b_addr[0], 32'h200);
    check_eq("pw_c1_wdata", b_wdata[0], 32'h0000_55AA);
    step(); @(negedge clk);
    check_eq("pw_c2_valid", 32'(valid[0]), 32'd0);
    step(); @(negedge clk);
    check_eq("pw_c3_valid", 32'(valid[0]), 32'd0);
    check_eq("pw_c3_req", 32'(b_req[0]), 32'd1);
    step(); @(negedge clk);
    check_eq("pw_c4_valid", 32'(valid[0]), 32'd0);
    check_eq("pw_c4_req", 32'(b_req[0]), 32'd0);
    step(); @(negedge clk);
    check_eq("pw_c5_req", 32'(b_req[0]), 32'd1);
    check_eq("pw_c5_we", 32'(b_we[0]), 32'd0);
    step();
    complete(0, "pw_rd");
    fixed_wait[0] = -1;

    // Unposted write: stalls until ack, returns zero data.
    fixed_wait[1] = 1;
    present(1, 1'b0, 4'b0011, 32'h200, 32'h0000_55AA);
    @(negedge clk);
    check_eq("nw_c0_valid", 32'(valid[1]), 32'd0);
    step(); @(negedge clk);
    check_eq("nw_c1_valid", 32'(valid[1]), 32'd0);
    check_eq("nw_c1_we", 32'(b_we[1]), 32'b0011);
    step(); @(negedge clk);
    check_eq("nw_c2_valid", 32'(valid[1]), 32'd0);
    step(); @(negedge clk);
    check_eq("nw_c3_valid", 32'(valid[1]), 32'd1);
    check_eq("nw_c3_rdata", rdata[1], 32'd0);
    cpu_ce[1] = 1'b1;
    step();
    ref_mem[1][128] = merge(ref_mem[1][128], 32'h0000_55AA, 4'b0011);
    cpu_ce[1] = 1'b0; we[1] = 4'd0;
    fixed_wait[1] = -1;
    run_access(1, 1'b1, 4'd0, 32'h200, $urandom, "nw_rdback");

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) step();
        kind = $urandom_range(0, 4);
        a    = 32'($urandom_range(0, 15)) << 2;
        wd   = $urandom;
        wev  = 4'($urandom_range(1, 15));
        if (kind < 2) run_access(d, 1'b1, 4'd0, a, wd, "rnd_rd");
        else if (kind < 4) run_access(d, 1'b0, wev, a, wd, "rnd_wr");
        else run_access(d, 1'b1, wev, a, wd, "rnd_rdwr");
      end
    end
    check_eq("p_no_err", 32'(err[0]), 32'd0);
    check_eq("n_no_err", 32'(err[1]), 32'd0);

    // Timeout on the TIMEOUT=4 instance, followed by a late ack.
    stall_ack[0] = 1'b1;
    present(0, 1'b1, 4'd0, 32'h104, $urandom);
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (valid[0]) seen = 1'b1;
      else begin
        if (b_req[0]) cnt++;
        step();
      end
    end
    check_eq("to_valid", 32'(valid[0]), 32'd1);
    check_eq("to_req_cycles", 32'(cnt), 32'd4);
    check_eq("to_err", 32'(err[0]), 32'd1);
    check_eq("to_rdata", rdata[0], 32'd0);
    step();
    inject_ack[0] = 1'b1;
    step(); @(negedge clk);
    check_eq("late_ack_valid", 32'(valid[0]), 32'd1);
    check_eq("late_ack_rdata", rdata[0], 32'd0);
    step(); @(negedge clk);
    check_eq("late_ack_req", 32'(b_req[0]), 32'd0);
    check_eq("late_ack_err", 32'(err[0]), 32'd1);
    cpu_ce[0] = 1'b1;
    step();
    cpu_ce[0] = 1'b0; rd[0] = 1'b0;
    stall_ack[0] = 1'b0;

    // Reset in the middle of a bus read, then a normal read.
    stall_ack[1] = 1'b1;
    present(1, 1'b1, 4'd0, 32'h108, $urandom);
    step(); @(negedge clk);
    check_eq("mr_req_before", 32'(b_req[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mr_req_async", 32'(b_req[1]), 32'd0);
    check_eq("mr_err_cleared", 32'(err[0]), 32'd0);
    rd[1] = 1'b0;
    #1 rst_n = 1'b1;
    stall_ack[1] = 1'b0;
    step();
    run_access(1, 1'b1, 4'd0, 32'h108, $urandom, "mr_rd");
    run_access(0, 1'b1, 4'd0, 32'h100, $urandom, "final_rd");

    check_eq("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
    check_eq("exp_q1_empty", 32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
